// File: rtl/gamma_mon_pkg.sv
// Shared FSM state type and saturation helpers for the column oscillator monitors.
package gamma_mon_pkg;

    localparam int GM_WIDTH = 18;

    function automatic logic [63:0] amp_max_of(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] amp_min_neg_of(input int width);
        return 64'd1 << (width - 1);
    endfunction

    localparam logic        [GM_WIDTH-1:0] AMP_MAX     = GM_WIDTH'(amp_max_of(GM_WIDTH));
    localparam logic signed [GM_WIDTH-1:0] AMP_MIN_NEG = GM_WIDTH'(amp_min_neg_of(GM_WIDTH));

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } gm_state_e;

endpackage

// File: rtl/gamma_amp_est.sv
// Combinational amplitude estimate of a 2-D oscillator state: max(|x|,|y|) + min(|x|,|y|)/2,
// with saturating absolute values and a saturated, never-negative result.
module gamma_amp_est
    import gamma_mon_pkg::*;
#(
    parameter int WIDTH = GM_WIDTH
) (
    input  logic signed [WIDTH-1:0] i_x,
    input  logic signed [WIDTH-1:0] i_y,
    output logic        [WIDTH-1:0] o_amp
);

    localparam logic [WIDTH-1:0] L_MAX =
        (WIDTH == GM_WIDTH) ? WIDTH'(AMP_MAX) : WIDTH'(amp_max_of(WIDTH));
    localparam logic [WIDTH-1:0] L_MIN_NEG =
        (WIDTH == GM_WIDTH) ? WIDTH'(AMP_MIN_NEG) : WIDTH'(amp_min_neg_of(WIDTH));

    logic [WIDTH-1:0] w_abs_x;
    logic [WIDTH-1:0] w_abs_y;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH:0]   w_sum;

    // The most negative code has no positive twin, so it folds onto the largest positive value.
    function automatic logic [WIDTH-1:0] sat_abs(input logic signed [WIDTH-1:0] v);
        if ($unsigned(v) == L_MIN_NEG) begin
            return L_MAX;
        end else if (v[WIDTH-1]) begin
            return $unsigned(-v);
        end else begin
            return $unsigned(v);
        end
    endfunction

    always_comb begin
        w_abs_x = sat_abs(i_x);
        w_abs_y = sat_abs(i_y);
        if (w_abs_x >= w_abs_y) begin
            w_hi = w_abs_x;
            w_lo = w_abs_y;
        end else begin
            w_hi = w_abs_y;
            w_lo = w_abs_x;
        end
        w_half = w_lo >> 1;
        w_sum  = {1'b0, w_hi} + {1'b0, w_half};
        o_amp  = (w_sum > {1'b0, L_MAX}) ? L_MAX : w_sum[WIDTH-1:0];
    end

endmodule

// File: rtl/l23_gamma_monitor.sv
// Windowed amplitude / rising-zero-crossing monitor for the L2/3 gamma oscillator.
// Define GAMMA_MON_ZC_EN to build the zero-crossing counter; otherwise zc_count is tied to 0.
module l23_gamma_monitor
    import gamma_mon_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int FRAC       = 14,
    parameter int SETTLE_LEN = 64,
    parameter int WIN_LEN    = 256,
    parameter int AMP_LIMIT  = 30000,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] l23_x,
    input  logic signed [WIDTH-1:0] l23_y,
    input  logic                    start,
    input  logic                    cont,
    input  logic                    abort,
    output logic        [WIDTH-1:0] amp,
    output logic        [WIDTH-1:0] win_max,
    output logic        [WIDTH-1:0] win_min,
    output logic        [CNT_W-1:0] zc_count,
    output logic                    win_valid,
    output logic                    busy,
    output logic                    runaway
);

    localparam int               L_CNT_SPAN    = (WIN_LEN > SETTLE_LEN) ? WIN_LEN : SETTLE_LEN;
    localparam int               L_CW          = $clog2(L_CNT_SPAN + 1);
    localparam logic [L_CW-1:0]  L_SETTLE_LAST = L_CW'(SETTLE_LEN - 1);
    localparam logic [L_CW-1:0]  L_WIN_LAST    = L_CW'(WIN_LEN - 1);
    localparam logic [WIDTH-1:0] L_AMP_MAX     = WIDTH'(amp_max_of(WIDTH));

    // FRAC only names the binary point for consumers of amp; no arithmetic here depends on it.
    if (FRAC < 0 || FRAC >= WIDTH) begin : g_frac_outside_word
    end

    gm_state_e        r_state;
    gm_state_e        w_state_next;
    logic [L_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] w_amp;
    logic [WIDTH-1:0] r_amp;
    logic [WIDTH-1:0] r_acc_max;
    logic [WIDTH-1:0] r_acc_min;
    logic [WIDTH-1:0] w_acc_max_next;
    logic [WIDTH-1:0] w_acc_min_next;
    logic [WIDTH-1:0] r_win_max;
    logic [WIDTH-1:0] r_win_min;
    logic             r_win_valid;
    logic             r_runaway;
    logic             w_busy;
    logic             w_start_run;
    logic             w_settle_ce;
    logic             w_measure_ce;
    logic             w_settle_last;
    logic             w_win_last;
    logic             w_rearm;
    logic             w_over_limit;

    gamma_amp_est #(
        .WIDTH (WIDTH)
    ) u_amp_est (
        .i_x   (l23_x),
        .i_y   (l23_y),
        .o_amp (w_amp)
    );

    // Abort outranks every sample-driven event, including the one that would close the window.
    assign w_start_run    = (r_state == ST_IDLE) && start;
    assign w_settle_ce    = (r_state == ST_SETTLE) && clk_en && !abort;
    assign w_measure_ce   = (r_state == ST_MEASURE) && clk_en && !abort;
    assign w_settle_last  = w_settle_ce && (r_cnt == L_SETTLE_LAST);
    assign w_win_last     = w_measure_ce && (r_cnt == L_WIN_LAST);
    assign w_rearm        = (r_state == ST_DONE) && !abort && cont;
    assign w_over_limit   = (32'(w_amp) > 32'(AMP_LIMIT));
    assign w_acc_max_next = (w_amp > r_acc_max) ? w_amp : r_acc_max;
    assign w_acc_min_next = (w_amp < r_acc_min) ? w_amp : r_acc_min;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (SETTLE_LEN > 0) ? ST_SETTLE : ST_MEASURE;
                end
            end
            ST_SETTLE: begin
                w_busy = 1'b1;
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_settle_last) begin
                    w_state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                w_busy = 1'b1;
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_win_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy = cont;
                if (abort || !cont) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_MEASURE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Results are published on the edge that consumes the last sample, so they and win_valid
    // are visible during the DONE cycle; the window uses the live estimate of each sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_amp       <= '0;
            r_acc_max   <= '0;
            r_acc_min   <= L_AMP_MAX;
            r_win_max   <= '0;
            r_win_min   <= '0;
            r_win_valid <= 1'b0;
            r_runaway   <= 1'b0;
        end else begin
            r_win_valid <= 1'b0;
            if (clk_en) begin
                r_amp <= w_amp;
            end
            if (w_start_run || w_rearm) begin
                r_cnt     <= '0;
                r_acc_max <= '0;
                r_acc_min <= L_AMP_MAX;
                if (w_start_run) begin
                    r_runaway <= 1'b0;
                end
            end else if (w_settle_ce) begin
                r_cnt <= w_settle_last ? '0 : r_cnt + L_CW'(1);
            end else if (w_measure_ce) begin
                r_cnt     <= r_cnt + L_CW'(1);
                r_acc_max <= w_acc_max_next;
                r_acc_min <= w_acc_min_next;
                if (w_over_limit) begin
                    r_runaway <= 1'b1;
                end
                if (w_win_last) begin
                    r_win_max   <= w_acc_max_next;
                    r_win_min   <= w_acc_min_next;
                    r_win_valid <= 1'b1;
                end
            end
        end
    end

`ifdef GAMMA_MON_ZC_EN
    logic             r_prev_x_neg;
    logic [CNT_W-1:0] r_zc;
    logic [CNT_W-1:0] r_zc_count;
    logic             w_rise;
    logic [CNT_W-1:0] w_zc_next;

    // Clearing prev on start makes the first sample of an unsettled run unable to cross.
    assign w_rise    = r_prev_x_neg && !l23_x[WIDTH-1];
    assign w_zc_next = (w_rise && (r_zc != '1)) ? r_zc + CNT_W'(1) : r_zc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_x_neg <= 1'b0;
            r_zc         <= '0;
            r_zc_count   <= '0;
        end else if (w_start_run) begin
            r_prev_x_neg <= 1'b0;
            r_zc         <= '0;
        end else if (w_rearm) begin
            r_zc <= '0;
        end else if (w_settle_ce) begin
            r_prev_x_neg <= l23_x[WIDTH-1];
        end else if (w_measure_ce) begin
            r_prev_x_neg <= l23_x[WIDTH-1];
            r_zc         <= w_zc_next;
            if (w_win_last) begin
                r_zc_count <= w_zc_next;
            end
        end
    end

    assign zc_count = r_zc_count;
`else
    assign zc_count = '0;
`endif

    assign amp       = r_amp;
    assign win_max   = r_win_max;
    assign win_min   = r_win_min;
    assign win_valid = r_win_valid;
    assign busy      = w_busy;
    assign runaway   = r_runaway;

endmodule

// File: tb/tb_l23_gamma_monitor.sv
// Scoreboard bench for l23_gamma_monitor: directed scenarios plus randomized traffic,
// checked against a window-level reference model.
module tb_l23_gamma_monitor;

    localparam int W      = 18;
    localparam int SETTLE = 3;
    localparam int WIN    = 8;
    localparam int LIMIT  = 30000;
    localparam int CW     = 16;
    localparam int AMAX   = (1 << (W - 1)) - 1;

    logic                clk;
    logic                rst_n;
    logic                clk_en;
    logic signed [W-1:0] l23_x;
    logic signed [W-1:0] l23_y;
    logic                start;
    logic                cont;
    logic                abort;
    logic [W-1:0]        amp;
    logic [W-1:0]        win_max;
    logic [W-1:0]        win_min;
    logic [CW-1:0]       zc_count;
    logic                win_valid;
    logic                busy;
    logic                runaway;

    l23_gamma_monitor #(
        .WIDTH      (W),
        .FRAC       (14),
        .SETTLE_LEN (SETTLE),
        .WIN_LEN    (WIN),
        .AMP_LIMIT  (LIMIT),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .l23_x     (l23_x),
        .l23_y     (l23_y),
        .start     (start),
        .cont      (cont),
        .abort     (abort),
        .amp       (amp),
        .win_max   (win_max),
        .win_min   (win_min),
        .zc_count  (zc_count),
        .win_valid (win_valid),
        .busy      (busy),
        .runaway   (runaway)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int amp;
        bit busy;
        bit run;
        bit valid;
        int rmax;
        int rmin;
        int rzc;
    } cyc_t;

    typedef struct {
        int mx;
        int mn;
        int zc;
    } res_t;

    cyc_t cyc_q[$];
    res_t res_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_win    = 0;
    bit   g_cont   = 1'b0;

    // Reference model: where the monitor is in its run, and the samples of the open window.
    int m_phase;        // 0 idle, 1 settling, 2 measuring, 3 window just closed
    int m_settle_left;
    int m_xs[$];
    int m_amps[$];
    bit m_pre_neg;
    bit m_last_neg;
    bit m_have_prev;
    int m_amp;
    bit m_run;
    bit m_valid;
    int m_rmax;
    int m_rmin;
    int m_rzc;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_amp(input int x, input int y);
        int ax;
        int ay;
        int s;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        if (ax > AMAX) ax = AMAX;
        if (ay > AMAX) ay = AMAX;
        s = (ax > ay) ? ax + ay / 2 : ay + ax / 2;
        return (s > AMAX) ? AMAX : s;
    endfunction

    function automatic void open_window();
        m_xs.delete();
        m_amps.delete();
        m_pre_neg = m_have_prev && m_last_neg;
    endfunction

    function automatic void close_window();
        int mx;
        int mn;
        int zc;
        bit prev;
        res_t r;
        mx   = 0;
        mn   = AMAX;
        zc   = 0;
        prev = m_pre_neg;
        foreach (m_xs[i]) begin
            if (m_amps[i] > mx) mx = m_amps[i];
            if (m_amps[i] < mn) mn = m_amps[i];
            if (prev && m_xs[i] >= 0 && zc < (1 << CW) - 1) zc++;
            prev = (m_xs[i] < 0);
        end
`ifndef GAMMA_MON_ZC_EN
        zc = 0;
`endif
        m_last_neg  = prev;
        m_have_prev = 1'b1;
        m_rmax  = mx;
        m_rmin  = mn;
        m_rzc   = zc;
        m_valid = 1'b1;
        r.mx = mx;
        r.mn = mn;
        r.zc = zc;
        res_q.push_back(r);
    endfunction

    function automatic void model_step(input bit r, input bit ce, input int x, input int y,
                                       input bit st, input bit ct, input bit ab);
        int   a;
        cyc_t e;
        m_valid = 1'b0;
        a = ref_amp(x, y);
        if (!r) begin
            m_phase = 0; m_amp = 0; m_run = 0; m_have_prev = 0; m_last_neg = 0;
            m_rmax = 0; m_rmin = 0; m_rzc = 0;
            m_xs.delete(); m_amps.delete();
        end else begin
            case (m_phase)
                0: if (st) begin
                    m_run = 0; m_have_prev = 0; m_last_neg = 0;
                    m_settle_left = SETTLE;
                    open_window();
                    m_phase = (SETTLE > 0) ? 1 : 2;
                end
                1: if (ab) m_phase = 0;
                   else if (ce) begin
                       m_last_neg  = (x < 0);
                       m_have_prev = 1'b1;
                       m_settle_left--;
                       if (m_settle_left == 0) begin
                           open_window();
                           m_phase = 2;
                       end
                   end
                2: if (ab) m_phase = 0;
                   else if (ce) begin
                       if (a > LIMIT) m_run = 1'b1;
                       m_xs.push_back(x);
                       m_amps.push_back(a);
                       if (m_xs.size() == WIN) begin
                           close_window();
                           m_phase = 3;
                       end
                   end
                default: if (ab || !ct) m_phase = 0;
                         else begin
                             open_window();
                             m_phase = 2;
                         end
            endcase
            if (ce) m_amp = a;
        end
        e.amp   = m_amp;
        e.busy  = (m_phase == 1) || (m_phase == 2) || (m_phase == 3 && ct);
        e.run   = m_run;
        e.valid = m_valid;
        e.rmax  = m_rmax;
        e.rmin  = m_rmin;
        e.rzc   = m_rzc;
        cyc_q.push_back(e);
    endfunction

    task automatic check_zero();
        chk("async_rst_amp", int'(amp), 0);
        chk("async_rst_win_max", int'(win_max), 0);
        chk("async_rst_win_min", int'(win_min), 0);
        chk("async_rst_zc", int'(zc_count), 0);
        chk("async_rst_valid", int'(win_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_runaway", int'(runaway), 0);
    endtask

    // Inputs for the coming edge are applied 2 time units after the previous edge.
    task automatic step(input bit r, input bit ce, input int x, input int y,
                        input bit st, input bit ab);
        bit drop;
        drop   = rst_n && !r;
        rst_n  = r;
        clk_en = ce;
        l23_x  = W'(x);
        l23_y  = W'(y);
        start  = st;
        cont   = g_cont;
        abort  = ab;
        model_step(r, ce, x, y, st, g_cont, ab);
        if (drop) begin
            #1;
            check_zero();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic run_const(input int n, input int x, input int y);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, x, y, 1'b0, 1'b0);
    endtask

    function automatic int rand_sample();
        int k;
        k = $urandom_range(0, 9);
        if (k < 5) return int'($urandom_range(0, 4000)) - 2000;
        if (k < 8) return int'($urandom_range(0, 262143)) - 131072;
        case ($urandom_range(0, 3))
            0:       return -131072;
            1:       return 131071;
            2:       return 0;
            default: return -1;
        endcase
    endfunction

    // Monitor: one expectation per clock, plus a result record whenever win_valid shows.
    initial begin
        cyc_t e;
        res_t r;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("amp", int'(amp), e.amp);
                chk("busy", int'(busy), int'(e.busy));
                chk("runaway", int'(runaway), int'(e.run));
                chk("win_valid", int'(win_valid), int'(e.valid));
                chk("held_win_max", int'(win_max), e.rmax);
                chk("held_win_min", int'(win_min), e.rmin);
                chk("held_zc", int'(zc_count), e.rzc);
                if (win_valid) begin
                    if (res_q.size() == 0) begin
                        chk("unexpected_win_valid", 1, 0);
                    end else begin
                        r = res_q.pop_front();
                        n_win++;
                        $display("window %0d: max=%0d min=%0d zc=%0d", n_win,
                                 int'(win_max), int'(win_min), int'(zc_count));
                        chk("win_max", int'(win_max), r.mx);
                        chk("win_min", int'(win_min), r.mn);
                        chk("zc_count", int'(zc_count), r.zc);
                    end
                end
            end
        end
    end

    initial begin
        int  x;
        bit  ab;
        rst_n = 1'b0; clk_en = 1'b0; l23_x = '0; l23_y = '0;
        start = 1'b0; cont = 1'b0; abort = 1'b0;

        // Reset state, then a constant-input single window.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16384, 0, 1'b1, 1'b0);
        run_const(SETTLE + WIN + 3, 16384, 0);

        // Mixed-sign amplitude, full-scale saturation, then a runaway window.
        run_const(2, -8192, 8192);
        run_const(2, -131072, -131072);
        step(1'b1, 1'b1, -131072, -131072, 1'b1, 1'b0);
        run_const(SETTLE + WIN + 2, -131072, -131072);

        // Square wave around zero after positive settle samples.
        step(1'b1, 1'b1, 1000, 0, 1'b1, 1'b0);
        run_const(SETTLE, 1000, 0);
        for (int i = 0; i < WIN + 2; i++) begin
            x = ((i / 2) % 2 == 0) ? -1000 : 1000;
            step(1'b1, 1'b1, x, 500, 1'b0, 1'b0);
        end

        // Continuous mode: back-to-back windows with busy held high.
        g_cont = 1'b1;
        step(1'b1, 1'b1, 2000, -300, 1'b1, 1'b0);
        for (int i = 0; i < SETTLE + 3 * (WIN + 1); i++) begin
            x = (i % 3 == 0) ? -700 : 900;
            step(1'b1, 1'b1, x, 100 * i, 1'b0, 1'b0);
        end
        g_cont = 1'b0;
        run_const(WIN + 2, 50, 50);

        // Abort on the very clock that would complete a runaway window.
        step(1'b1, 1'b1, 40000, 0, 1'b1, 1'b0);
        for (int i = 0; i < SETTLE + WIN + 2; i++) begin
            ab = (m_phase == 2) && (m_xs.size() == WIN - 1);
            step(1'b1, 1'b1, 40000 - 100 * i, 0, 1'b0, ab);
            if (ab) break;
        end
        run_const(3, 10, 10);

        // Asynchronous reset mid-measure, then a clean window after release.
        step(1'b1, 1'b1, 3000, 3000, 1'b1, 1'b0);
        run_const(SETTLE + 3, 3000, 3000);
        step(1'b0, 1'b1, 3000, 3000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1200, -400, 1'b1, 1'b0);
        run_const(SETTLE + WIN + 2, 1200, -400);

        // Randomized traffic: sparse clk_en, stray starts/aborts, toggling continuous mode.
        for (int i = 0; i < 1500; i++) begin
            if (i % 97 == 0) g_cont = ($urandom_range(0, 1) == 1);
            step(1'b1, ($urandom_range(0, 9) < 7), rand_sample(), rand_sample(),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 59) == 0));
        end
        g_cont = 1'b0;
        run_const(SETTLE + WIN + 4, 0, 0);

        chk("pending_results", res_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
